rvv_uop_queue: RTL and testbench

- Uops Queue that directly consumes the decode unit's output.
- Accepts up to `NUM_DE_UOP decoded uops per cycle and buffers them in order in a circular register file.
- Presents up to `NUM_DP_UOP oldest uops per cycle to the dispatch stage.
- Back-pressures the decoder with a registered all-or-nothing ready, so the decoder never sees a partial acceptance.

---
 rtl/rvv_uop_queue_pkg.sv | 23 ++
 rtl/rvv_multi_port_fifo.sv | 94 +++++++++
 rtl/rvv_uop_queue_chk.sv | 35 +++
 rtl/rvv_uop_queue.sv | 72 +++++++
 tb/tb_rvv_uop_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rvv_uop_queue_pkg.sv
// Shared types and sizing for the vector uop queue between decode and dispatch.
package rvv_uop_queue_pkg;

  localparam int NUM_DE_UOP = 4;   // uops produced by decode per cycle
  localparam int NUM_DP_UOP = 2;   // uops offered to dispatch per cycle
  localparam int UQ_DEPTH   = 16;  // queue entries

  typedef enum logic [1:0] {
    UOP_ALU = 2'd0,
    UOP_LSU = 2'd1,
    UOP_MUL = 2'd2,
    UOP_PMT = 2'd3
  } uop_class_e;

  typedef struct packed {
    logic [31:0] insn;       // originating vector instruction
    logic [2:0]  uop_index;  // position of this uop within the instruction
    logic        uop_last;   // final uop of the instruction
    uop_class_e  uop_class;  // execution pipe selector
    logic [1:0]  rsvd;
  } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_multi_port_fifo.sv
// Generic N-push / M-pop circular buffer. Pushes are taken from slot 0 upward,
// pops release the oldest entries; both may happen in the same cycle.
module rvv_multi_port_fifo #(
  parameter type DATA_T    = logic [7:0],
  parameter int  DEPTH     = 16,
  parameter int  NUM_PUSH  = 4,
  parameter int  NUM_POP   = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1,
  localparam int PUSH_CW   = $clog2(NUM_PUSH + 1),
  localparam int POP_CW    = $clog2(NUM_POP + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push_en,
  input  logic [NUM_PUSH-1:0]        push_valid,
  input  DATA_T [NUM_PUSH-1:0]       push_data,
  output logic [NUM_POP-1:0]         pop_valid,
  output DATA_T [NUM_POP-1:0]        pop_data,
  input  logic [NUM_POP-1:0]         pop_req,
  output logic [CNT_W-1:0]           count
);

  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [CNT_W-1:0]   count_r;
  DATA_T              mem_r [DEPTH];
  logic [PUSH_CW-1:0] npush_s;
  logic [POP_CW-1:0]  npop_s;

  // Number of slots accepted this cycle (thermometer valids, gated by push_en).
  always_comb begin
    npush_s = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (push_en && push_valid[i]) begin
        npush_s = npush_s + PUSH_CW'(1);
      end else begin
        npush_s = npush_s;
      end
    end
  end

  // Number of entries released; requests on empty slots do not count.
  always_comb begin
    npop_s = '0;
    for (int i = 0; i < NUM_POP; i++) begin
      if (pop_req[i] && pop_valid[i]) begin
        npop_s = npop_s + POP_CW'(1);
      end else begin
        npop_s = npop_s;
      end
    end
  end

  // Oldest entries presented straight from registered state (no push bypass).
  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    for (int i = 0; i < NUM_POP; i++) begin
      pop_valid[i] = (count_r > CNT_W'(i));
      pop_data[i]  = mem_r[rptr_r + PTR_W'(i)];
    end
  end

  // Pointer and occupancy update; clr wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else if (clr) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      wptr_r  <= wptr_r + PTR_W'(npush_s);
      rptr_r  <= rptr_r + PTR_W'(npop_s);
      count_r <= count_r + CNT_W'(npush_s) - CNT_W'(npop_s);
    end
  end

  // Entry storage; contents carry no reset, only pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (!clr && (PUSH_CW'(i) < npush_s)) begin
        mem_r[wptr_r + PTR_W'(i)] <= push_data[i];
      end
    end
  end

  assign count = count_r;

endmodule

// File: rtl/rvv_uop_queue_chk.sv
// Interface protocol and occupancy checks for the uop queue.
module rvv_uop_queue_chk
  import rvv_uop_queue_pkg::*;
#(
  parameter int DEPTH    = UQ_DEPTH,
  parameter int NUM_PUSH = NUM_DE_UOP,
  parameter int NUM_POP  = NUM_DP_UOP,
  parameter int CNT_W    = $clog2(UQ_DEPTH) + 1
) (
  input logic                        clk,
  input logic                        rst_n,
  input logic [NUM_PUSH-1:0]         uop_valid_de2uq,
  input UOP_QUEUE_t [NUM_PUSH-1:0]   uop_de2uq,
  input logic                        uq_ready_uq2de,
  input logic [NUM_POP-1:0]          uop_valid_uq2dp,
  input logic [NUM_POP-1:0]          uop_pop_dp2uq,
  input logic [CNT_W-1:0]            uq_count
);

  a_push_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    (uop_valid_de2uq & (uop_valid_de2uq + NUM_PUSH'(1))) == '0);

  a_pop_thermo: assert property (@(posedge clk) disable iff (!rst_n)
    (uop_pop_dp2uq & (uop_pop_dp2uq + NUM_POP'(1))) == '0);

  a_pop_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (uop_pop_dp2uq & ~uop_valid_uq2dp) == '0);

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    uq_count <= CNT_W'(DEPTH));

  a_push_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ((|uop_valid_de2uq) && !uq_ready_uq2de) |=> $stable(uop_de2uq));

endmodule

// File: rtl/rvv_uop_queue.sv
// Uop queue between vector decode and dispatch: wraps the multi-port FIFO,
// adds the all-or-nothing registered-count ready policy and flush.
module rvv_uop_queue
  import rvv_uop_queue_pkg::*;
#(
  parameter int  DEPTH    = UQ_DEPTH,
  parameter int  NUM_PUSH = NUM_DE_UOP,
  parameter int  NUM_POP  = NUM_DP_UOP,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PUSH-1:0]        uop_valid_de2uq,
  input  UOP_QUEUE_t [NUM_PUSH-1:0]  uop_de2uq,
  output logic                       uq_ready_uq2de,
  output logic [NUM_POP-1:0]         uop_valid_uq2dp,
  output UOP_QUEUE_t [NUM_POP-1:0]   uop_uq2dp,
  input  logic [NUM_POP-1:0]         uop_pop_dp2uq,
  input  logic                       flush,
  output logic                       uq_empty,
  output logic [CNT_W-1:0]           uq_count
);

  logic [CNT_W-1:0] count_s;

  rvv_multi_port_fifo #(
    .DATA_T   (UOP_QUEUE_t),
    .DEPTH    (DEPTH),
    .NUM_PUSH (NUM_PUSH),
    .NUM_POP  (NUM_POP)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .push_en    (uq_ready_uq2de),
    .push_valid (uop_valid_de2uq),
    .push_data  (uop_de2uq),
    .pop_valid  (uop_valid_uq2dp),
    .pop_data   (uop_uq2dp),
    .pop_req    (uop_pop_dp2uq),
    .count      (count_s)
  );

  // Ready needs room for a whole decode group from the registered count;
  // same-cycle pops are deliberately not credited to keep pop off this path.
  always_comb begin
    uq_ready_uq2de = ((CNT_W'(DEPTH) - count_s) >= CNT_W'(NUM_PUSH));
  end

  // Occupancy status derived from the registered count.
  always_comb begin
    uq_count = count_s;
    uq_empty = (count_s == '0);
  end

  rvv_uop_queue_chk #(
    .DEPTH    (DEPTH),
    .NUM_PUSH (NUM_PUSH),
    .NUM_POP  (NUM_POP),
    .CNT_W    (CNT_W)
  ) u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .uop_valid_de2uq (uop_valid_de2uq),
    .uop_de2uq       (uop_de2uq),
    .uq_ready_uq2de  (uq_ready_uq2de),
    .uop_valid_uq2dp (uop_valid_uq2dp),
    .uop_pop_dp2uq   (uop_pop_dp2uq),
    .uq_count        (uq_count)
  );

endmodule

// File: tb/tb_rvv_uop_queue.sv
// Directed bench for rvv_uop_queue with a queue-based reference model.
module tb_rvv_uop_queue;
  import rvv_uop_queue_pkg::*;

  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [3:0]            uop_valid_de2uq;
  UOP_QUEUE_t [3:0]      uop_de2uq;
  logic                  uq_ready_uq2de;
  logic [1:0]            uop_valid_uq2dp;
  UOP_QUEUE_t [1:0]      uop_uq2dp;
  logic [1:0]            uop_pop_dp2uq;
  logic                  flush;
  logic                  uq_empty;
  logic [4:0]            uq_count;

  int checks   = 0;
  int failures = 0;

  UOP_QUEUE_t mq [$];
  int         m_sz;
  int         m_npop;

  always #5 clk = ~clk;

  rvv_uop_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uop_valid_de2uq (uop_valid_de2uq),
    .uop_de2uq       (uop_de2uq),
    .uq_ready_uq2de  (uq_ready_uq2de),
    .uop_valid_uq2dp (uop_valid_uq2dp),
    .uop_uq2dp       (uop_uq2dp),
    .uop_pop_dp2uq   (uop_pop_dp2uq),
    .flush           (flush),
    .uq_empty        (uq_empty),
    .uq_count        (uq_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic UOP_QUEUE_t mk(input logic [7:0] tag);
    UOP_QUEUE_t u;
    u.insn      = {24'h00C057, tag};
    u.uop_index = tag[2:0];
    u.uop_last  = tag[0];
    u.uop_class = uop_class_e'(tag[1:0]);
    u.rsvd      = 2'b00;
    return u;
  endfunction

  // Pop everything currently available (thermometer, never on empty slots).
  function automatic logic [1:0] popall();
    if (mq.size() >= 2) return 2'b11;
    else if (mq.size() == 1) return 2'b01;
    else return 2'b00;
  endfunction

  // Reference model: an ordered list of uops updated by the queue's rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      m_sz   = mq.size();
      m_npop = 0;
      for (int i = 0; i < 2; i++)
        if (uop_pop_dp2uq[i] && i < m_sz) m_npop++;
      for (int i = 0; i < m_npop; i++) void'(mq.pop_front());
      if (DEPTH - m_sz >= 4)
        for (int i = 0; i < 4; i++)
          if (uop_valid_de2uq[i]) mq.push_back(uop_de2uq[i]);
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ready", uq_ready_uq2de, (DEPTH - mq.size()) >= 4);
    chk("count", uq_count, mq.size());
    chk("empty", uq_empty, mq.size() == 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), uop_valid_uq2dp[i], mq.size() > i);
      if (mq.size() > i) chk($sformatf("data%0d", i), uop_uq2dp[i], mq[i]);
    end
  end

  // One cycle: drive at a negedge, return at the next negedge.
  task automatic cyc(input logic [3:0] v, input logic [7:0] tag,
                     input logic [1:0] pop, input logic fl);
    uop_valid_de2uq = v;
    if (v != 4'b0000)
      for (int i = 0; i < 4; i++) uop_de2uq[i] = mk(tag + 8'(i));
    uop_pop_dp2uq = pop;
    flush         = fl;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] t;
    rst_n           = 1'b0;
    uop_valid_de2uq = 4'b0000;
    uop_de2uq       = '0;
    uop_pop_dp2uq   = 2'b00;
    flush           = 1'b0;

    #12;
    chk("rst_ready", uq_ready_uq2de, 1'b1);
    chk("rst_valid", uop_valid_uq2dp, 2'b00);
    chk("rst_empty", uq_empty, 1'b1);
    chk("rst_count", uq_count, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First group visible one cycle later.
    cyc(4'b1111, 8'hA0, 2'b00, 1'b0);
    chk("p1_valid", uop_valid_uq2dp, 2'b11);
    chk("p1_d0", uop_uq2dp[0], mk(8'hA0));
    chk("p1_d1", uop_uq2dp[1], mk(8'hA1));
    chk("p1_count", uq_count, 5'd4);

    // Fill to full.
    cyc(4'b1111, 8'hA4, 2'b00, 1'b0);
    cyc(4'b1111, 8'hA8, 2'b00, 1'b0);
    cyc(4'b1111, 8'hAC, 2'b00, 1'b0);
    chk("full_count", uq_count, 5'd16);
    chk("full_ready", uq_ready_uq2de, 1'b0);

    // Push while full is ignored; the pop still applies.
    cyc(4'b1111, 8'hB0, 2'b11, 1'b0);
    chk("fpop_count", uq_count, 5'd14);
    chk("fpop_ready", uq_ready_uq2de, 1'b0);
    chk("fpop_d0", uop_uq2dp[0], mk(8'hA2));
    cyc(4'b0000, 8'h00, 2'b11, 1'b0);
    chk("c12_count", uq_count, 5'd12);
    chk("c12_ready", uq_ready_uq2de, 1'b1);

    // Simultaneous push and pop at count 12.
    cyc(4'b1111, 8'hC0, 2'b11, 1'b0);
    chk("pp_count", uq_count, 5'd14);
    cyc(4'b0000, 8'h00, 2'b11, 1'b0);
    chk("pp2_count", uq_count, 5'd12);
    chk("pp2_d0", uop_uq2dp[0], mk(8'hA8));

    // Drain.
    for (int k = 0; k < 12 && mq.size() > 0; k++) cyc(4'b0000, 8'h00, popall(), 1'b0);
    chk("drain_empty", uq_empty, 1'b1);

    // Steady 3-wide push / 2-wide pop across many pointer wraps.
    t = 8'h10;
    for (int k = 0; k < 40; k++) begin
      if (mq.size() <= DEPTH - 4) begin
        cyc(4'b0111, t, popall(), 1'b0);
        t = t + 8'd3;
      end else begin
        cyc(4'b0000, t, popall(), 1'b0);
      end
    end
    for (int k = 0; k < 12 && mq.size() > 0; k++) cyc(4'b0000, 8'h00, popall(), 1'b0);
    chk("wrap_count", uq_count, 5'd0);

    // Flush beats push and pop in the same cycle.
    cyc(4'b1111, 8'hE0, 2'b00, 1'b0);
    cyc(4'b1111, 8'hE4, 2'b00, 1'b0);
    cyc(4'b0001, 8'hE8, 2'b00, 1'b0);
    chk("pre_flush_count", uq_count, 5'd9);
    cyc(4'b1111, 8'hF0, 2'b11, 1'b1);
    chk("flush_count", uq_count, 5'd0);
    chk("flush_valid", uop_valid_uq2dp, 2'b00);
    chk("flush_empty", uq_empty, 1'b1);

    // Asynchronous reset in the middle of operation.
    cyc(4'b1111, 8'h20, 2'b00, 1'b0);
    cyc(4'b0111, 8'h24, 2'b00, 1'b0);
    chk("pre_rst_count", uq_count, 5'd7);
    uop_valid_de2uq = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", uq_ready_uq2de, 1'b1);
    chk("mrst_valid", uop_valid_uq2dp, 2'b00);
    chk("mrst_empty", uq_empty, 1'b1);
    chk("mrst_count", uq_count, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001, 8'hB0, 2'b00, 1'b0);
    chk("b0_d0", uop_uq2dp[0], mk(8'hB0));
    chk("b0_valid", uop_valid_uq2dp, 2'b01);
    chk("b0_count", uq_count, 5'd1);
    cyc(4'b0000, 8'h00, 2'b01, 1'b0);
    chk("end_count", uq_count, 5'd0);
    cyc(4'b0000, 8'h00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
